// File: rtl/maxpool_pkg.sv
// Shared constants and state encoding for the max-pool datapath.
// Optional feature macro: MAXPOOL_FEEDER_PAD_EN. When it is defined, the
// window grid covers partial windows at the right and bottom frame edges,
// and those windows read out-of-frame elements as PAD_VAL.
package maxpool_pkg;

   localparam int IMG_W    = 7;
   localparam int IMG_H    = 7;
   localparam int PIX_W    = 4;
   localparam int WIN      = 2;
   localparam int STRIDE   = 2;

   localparam int NPIX     = IMG_W * IMG_H;
   localparam int ADDR_W   = $clog2(NPIX);
   // Wide enough for any pixel coordinate, including padded ones.
   localparam int COORD_W  = ADDR_W + 1;
   localparam int WIN_BITS = WIN * WIN * PIX_W;

`ifdef MAXPOOL_FEEDER_PAD_EN
   localparam int OUT_W = (IMG_W - WIN + STRIDE - 1) / STRIDE + 1;
   localparam int OUT_H = (IMG_H - WIN + STRIDE - 1) / STRIDE + 1;
`else
   localparam int OUT_W = (IMG_W - WIN) / STRIDE + 1;
   localparam int OUT_H = (IMG_H - WIN) / STRIDE + 1;
`endif

   localparam logic [PIX_W-1:0] PAD_VAL = {PIX_W{1'b0}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/maxpool_frame_buf.sv
// Frame storage: one pixel register per frame location, synchronous write,
// combinational read. Not cleared by reset, so a loaded frame survives it.
import maxpool_pkg::*;

module maxpool_frame_buf (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [PIX_W-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [PIX_W-1:0]  rdata_o
);

   logic [PIX_W-1:0] mem_q [NPIX];

   // Store a pixel; addresses past the frame are dropped.
   always_ff @(posedge clk) begin
      if (we_i && (int'(waddr_i) < NPIX)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = (int'(raddr_i) < NPIX) ? mem_q[raddr_i] : PAD_VAL;

endmodule

// File: rtl/maxpool_window_feeder.sv
// Streams the stored frame as WIN x WIN windows in raster order over a
// valid/ready handshake, gathering one pixel per cycle.
// Optional feature macro: MAXPOOL_FEEDER_PAD_EN (zero-padded edge windows).
import maxpool_pkg::*;

module maxpool_window_feeder (
   input  logic                clk,
   input  logic                rst,
   input  logic                ld_en,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [PIX_W-1:0]    ld_data,
   input  logic                start,
   output logic                win_valid,
   input  logic                win_ready,
   output logic [WIN_BITS-1:0] win_data,
   output logic                win_last,
   output logic                busy,
   output logic                done
);

   localparam logic [COORD_W-1:0] ZERO_C     = {COORD_W{1'b0}};
   localparam logic [COORD_W-1:0] ONE_C      = {{(COORD_W-1){1'b0}}, 1'b1};
   localparam logic [COORD_W-1:0] STEP_C     = COORD_W'(STRIDE);
   localparam logic [COORD_W-1:0] LAST_E_C   = COORD_W'(WIN - 1);
   localparam logic [COORD_W-1:0] LAST_ROW_C = COORD_W'((OUT_H - 1) * STRIDE);
   localparam logic [COORD_W-1:0] LAST_COL_C = COORD_W'((OUT_W - 1) * STRIDE);

   state_e               state_q;
   // Top-left corner of the current window, already scaled by STRIDE.
   logic [COORD_W-1:0]   row_base_q, col_base_q;
   // Position of the next element inside the window.
   logic [COORD_W-1:0]   er_q, ec_q;
   logic [WIN_BITS-1:0]  win_buf_q;
   logic [WIN_BITS-1:0]  win_data_q;
   logic                 win_valid_q, win_last_q, busy_q, done_q;

   logic [COORD_W-1:0]   pix_row_s, pix_col_s;
   logic [ADDR_W-1:0]    rd_addr_s;
   logic [PIX_W-1:0]     rd_pix_s, pix_s;
   logic                 last_elem_s, frame_we_s;

   assign frame_we_s = ld_en && (state_q == IDLE);

   maxpool_frame_buf u_frame_buf (
      .clk     (clk),
      .we_i    (frame_we_s),
      .waddr_i (ld_addr),
      .wdata_i (ld_data),
      .raddr_i (rd_addr_s),
      .rdata_o (rd_pix_s)
   );

   // Address of the element being fetched and its (possibly padded) value.
   always_comb begin
      pix_row_s   = row_base_q + er_q;
      pix_col_s   = col_base_q + ec_q;
      rd_addr_s   = ADDR_W'(int'(pix_row_s) * IMG_W + int'(pix_col_s));
      last_elem_s = (er_q == LAST_E_C) && (ec_q == LAST_E_C);
`ifdef MAXPOOL_FEEDER_PAD_EN
      if ((int'(pix_row_s) < IMG_H) && (int'(pix_col_s) < IMG_W)) begin
         pix_s = rd_pix_s;
      end else begin
         pix_s = PAD_VAL;
      end
`else
      pix_s = rd_pix_s;
`endif
   end

   // Frame sequencing FSM with registered window outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         row_base_q  <= ZERO_C;
         col_base_q  <= ZERO_C;
         er_q        <= ZERO_C;
         ec_q        <= ZERO_C;
         win_buf_q   <= {WIN_BITS{1'b0}};
         win_data_q  <= {WIN_BITS{1'b0}};
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               row_base_q <= ZERO_C;
               col_base_q <= ZERO_C;
               er_q       <= ZERO_C;
               ec_q       <= ZERO_C;
               done_q     <= 1'b0;
               if (start) begin
                  busy_q  <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               // Shift in from the top so element 0 ends in the LSBs.
               win_buf_q <= {pix_s, win_buf_q[WIN_BITS-1:PIX_W]};
               if (last_elem_s) begin
                  er_q        <= ZERO_C;
                  ec_q        <= ZERO_C;
                  win_data_q  <= {pix_s, win_buf_q[WIN_BITS-1:PIX_W]};
                  win_valid_q <= 1'b1;
                  win_last_q  <= (row_base_q == LAST_ROW_C) && (col_base_q == LAST_COL_C);
                  state_q     <= PRESENT;
               end else if (ec_q == LAST_E_C) begin
                  ec_q <= ZERO_C;
                  er_q <= er_q + ONE_C;
               end else begin
                  ec_q <= ec_q + ONE_C;
               end
            end
            PRESENT: begin
               if (win_ready) begin
                  win_valid_q <= 1'b0;
                  win_last_q  <= 1'b0;
                  if (win_last_q) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     if (col_base_q == LAST_COL_C) begin
                        col_base_q <= ZERO_C;
                        row_base_q <= row_base_q + STEP_C;
                     end else begin
                        col_base_q <= col_base_q + STEP_C;
                     end
                     state_q <= FETCH;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign win_valid = win_valid_q;
   assign win_data  = win_data_q;
   assign win_last  = win_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_maxpool_window_feeder.sv
// Self-checking bench for maxpool_window_feeder. The expected windows come
// from a pixel-array model of the frame and the window-grid arithmetic.
// Honours MAXPOOL_FEEDER_PAD_EN when it is defined for the build.
module tb_maxpool_window_feeder;

   localparam int W  = 7;
   localparam int H  = 7;
   localparam int WN = 2;
   localparam int ST = 2;
`ifdef MAXPOOL_FEEDER_PAD_EN
   localparam int OW = 4;
   localparam int OH = 4;
`else
   localparam int OW = 3;
   localparam int OH = 3;
`endif
   localparam int NWIN = OW * OH;
   localparam int LAT  = WN * WN;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_en;
   logic [5:0]  ld_addr;
   logic [3:0]  ld_data;
   logic        start;
   logic        win_valid;
   logic        win_ready;
   logic [15:0] win_data;
   logic        win_last;
   logic        busy;
   logic        done;

   int          tests = 0;
   int          fails = 0;
   logic [3:0]  model [W*H];
   logic [15:0] got   [16];

   maxpool_window_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .start     (start),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .win_data  (win_data),
      .win_last  (win_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Window k of the grid: element e at row r*ST + e/WN, column c*ST + e%WN.
   function automatic logic [15:0] exp_win(input int k);
      logic [15:0] v;
      int r, c, row, col;
      v = 16'h0000;
      r = k / OW;
      c = k % OW;
      for (int e = 0; e < WN * WN; e++) begin
         row = r * ST + e / WN;
         col = c * ST + e % WN;
         if (row < H && col < W) v[e*4 +: 4] = model[row*W + col];
      end
      return v;
   endfunction

   task automatic load_pix(input int a, input logic [3:0] d);
      ld_en   = 1'b1;
      ld_addr = 6'(a);
      ld_data = d;
      @(posedge clk);
      @(negedge clk);
      ld_en = 1'b0;
      if (a < W * H) model[a] = d;
   endtask

   // One frame. rmode 1 randomises ready; stall_win, poke_win and rst_win
   // pick the window that gets a 10-cycle stall, an ignored start/ld_en, or
   // a reset (negative = none). ld_new writes pixel 0 in the start cycle.
   task automatic run_frame(input string tag, input int rmode, input int stall_win,
                            input int poke_win, input int rst_win, input int ld_new);
      int idx, cyc, first_valid, done_cyc, done_cnt, stall_left;
      bit stalled, poked;
      idx = 0; cyc = 0; first_valid = -1; done_cyc = -1; done_cnt = 0;
      stall_left = 0; stalled = 1'b0; poked = 1'b0;
      win_ready = (rmode == 0);
      start = 1'b1;
      if (ld_new != 0) begin
         ld_en   = 1'b1;
         ld_addr = 6'd0;
         ld_data = model[0] ^ 4'h9;
         model[0] = model[0] ^ 4'h9;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      ld_en = 1'b0;
      while (cyc < 600 && !(done_cyc >= 0 && cyc >= done_cyc + 2)) begin
         check({tag, " busy"}, busy, (done_cyc < 0 || cyc == done_cyc));
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (win_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (idx == rst_win) begin
               rst = 1'b0;
               #1;
               check({tag, " rst valid"}, win_valid, 0);
               check({tag, " rst data"},  win_data,  0);
               check({tag, " rst last"},  win_last,  0);
               check({tag, " rst busy"},  busy,      0);
               check({tag, " rst done"},  done,      0);
               win_ready = 1'b0;
               @(negedge clk);
               rst = 1'b1;
               @(negedge clk);
               @(negedge clk);
               check({tag, " post-rst valid"}, win_valid, 0);
               check({tag, " post-rst busy"},  busy,      0);
               check({tag, " post-rst done"},  done,      0);
               return;
            end
            if (idx >= NWIN) begin
               check({tag, " extra window"}, idx, NWIN - 1);
            end else begin
               check({tag, " data"}, win_data, exp_win(idx));
               check({tag, " last"}, win_last, (idx == NWIN - 1));
            end
            if (idx == poke_win && !poked) begin
               poked   = 1'b1;
               start   = 1'b1;
               ld_en   = 1'b1;
               ld_addr = 6'($urandom_range(0, W * H - 1));
               ld_data = model[ld_addr] ^ 4'hF;
            end
            if (idx == stall_win && !stalled) begin
               stalled    = 1'b1;
               stall_left = 10;
            end
            if (stall_left > 0) begin
               win_ready = 1'b0;
               stall_left--;
            end else if (rmode == 1) begin
               win_ready = 1'($urandom_range(0, 1));
            end else begin
               win_ready = 1'b1;
            end
            if (win_ready) begin
               if (idx < 16) got[idx] = win_data;
               idx++;
            end
         end else begin
            win_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
         start = 1'b0;
         ld_en = 1'b0;
      end
      check({tag, " windows"}, idx, NWIN);
      check({tag, " done pulses"}, done_cnt, 1);
      check({tag, " busy end"}, busy, 0);
      if (rmode == 0 && stall_win < 0 && poke_win < 0) begin
         check({tag, " first valid"}, first_valid, LAT);
         check({tag, " done cycle"}, done_cyc, NWIN * (LAT + 1));
      end
   endtask

   initial begin
      rst = 1'b0; ld_en = 1'b0; ld_addr = 6'd0; ld_data = 4'h0;
      start = 1'b0; win_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset valid", win_valid, 0);
      check("reset data",  win_data,  0);
      check("reset last",  win_last,  0);
      check("reset busy",  busy,      0);
      check("reset done",  done,      0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < W * H; i++) load_pix(i, 4'(i % 16));
`ifdef MAXPOOL_FEEDER_PAD_EN
      load_pix(48, 4'hF);
`endif
      load_pix(63, 4'hA);

      run_frame("plain", 0, -1, -1, -1, 0);
      check("plain w0", got[0], 16'h8710);
`ifdef MAXPOOL_FEEDER_PAD_EN
      check("pad w3",  got[3],  16'h0D06);
      check("pad w15", got[15], 16'h000F);
`else
      check("plain w2", got[2], 16'hCB54);
      check("plain w3", got[3], 16'h65FE);
      check("plain w8", got[8], 16'h8710);
`endif

      run_frame("stall", 0, 1, -1, -1, 0);
      run_frame("poke",  1, -1, 2, -1, 0);
      run_frame("reset", 0, -1, -1, 5, 0);
      run_frame("after-reset", 0, -1, -1, -1, 0);
      check("after-reset w0", got[0], 16'h8710);
      run_frame("ld+start", 0, -1, -1, -1, 1);
      check("ld+start w0", got[0], 16'h8719);

      for (int i = 0; i < W * H; i++) load_pix(i, 4'($urandom_range(0, 15)));
      run_frame("random", 1, -1, -1, -1, 0);
      run_frame("random stall", 1, 0, -1, -1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
